dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_if.sv | 37 +++
 rtl/dm_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if -- bundle of the core-side request bus and the memory-side
// bus seen by the data-memory arbiter.
//   Core side : req, we, addr, wdata (to arbiter); gnt, rvalid, rdata (back)
//   Memory side: mem_en, mem_we, mem_addr, mem_wdata (to memory); mem_rdata
//   Status    : busy
// Modports:
//   slave  -- the arbiter itself
//   master -- the environment (cores plus memory) driving/observing it
interface dm_arbiter_if #(
  parameter int NCORE = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
);
  logic [NCORE-1:0]    req;
  logic [NCORE-1:0]    we;
  logic [NCORE*AW-1:0] addr;
  logic [NCORE*DW-1:0] wdata;
  logic [NCORE-1:0]    gnt;
  logic [NCORE-1:0]    rvalid;
  logic [DW-1:0]       rdata;
  logic                mem_en;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;
  logic                busy;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter -- round-robin arbiter giving NCORE cores access to a single
// data memory port, one access at a time.
// Ports:
//   clk    : single clock, all state changes on posedge
//   rst_n  : synchronous active-low reset
//   bus    : dm_arbiter_if.slave
//            req/we/addr/wdata  per-core requests (packed, core i at [i*W +: W])
//            gnt/rvalid         one-hot, one-cycle grant / read-valid pulses
//            rdata              shared read data, held between rvalid pulses
//            mem_*              memory strobe, write enable, address, data
//            mem_rdata          memory read data, valid the cycle after a read
//            busy               high whenever the FSM is not idle
// Timing: a request is sampled in IDLE; the next cycle is ISSUE (mem_en and
// gnt high). Writes return to IDLE after ISSUE; reads pass through RDWAIT,
// where mem_rdata is captured, and rvalid appears in the following cycle.
module dm_arbiter #(
  parameter int NCORE = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dm_arbiter_if.slave    bus
);

  localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RDWAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // r_last is both the round-robin pointer and the index of the core whose
  // access is in flight, since the winner becomes "last" at capture.
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    w_last_next;

  logic [NCORE-1:0] r_gnt,    w_gnt_next;
  logic [NCORE-1:0] r_rvalid, w_rvalid_next;
  logic [DW-1:0]    r_rdata,  w_rdata_next;
  logic             r_mem_en, w_mem_en_next;
  logic             r_mem_we, w_mem_we_next;
  logic [AW-1:0]    r_mem_addr,  w_mem_addr_next;
  logic [DW-1:0]    r_mem_wdata, w_mem_wdata_next;
  logic             r_busy,   w_busy_next;

  logic             w_found;
  logic [IW-1:0]    w_winner;

  // Round-robin search: first requesting core at (last+1), (last+2), ...
  // wrapping around; last itself is checked last so a lone requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    for (int k = 1; k <= NCORE; k++) begin
      if (!w_found && bus.req[(int'(r_last) + k) % NCORE]) begin
        w_found  = 1'b1;
        w_winner = IW'((int'(r_last) + k) % NCORE);
      end
    end
  end

  // Next-state and next-output logic. The memory-side registers double as
  // the captured request, so they hold their values outside ISSUE.
  always_comb begin
    w_state_next     = r_state;
    w_last_next      = r_last;
    w_gnt_next       = '0;
    w_rvalid_next    = '0;
    w_rdata_next     = r_rdata;
    w_mem_en_next    = 1'b0;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_last_next            = w_winner;
          w_gnt_next[w_winner]   = 1'b1;
          w_mem_en_next          = 1'b1;
          w_mem_we_next          = bus.we[w_winner];
          w_mem_addr_next        = bus.addr[int'(w_winner)*AW +: AW];
          w_mem_wdata_next       = bus.wdata[int'(w_winner)*DW +: DW];
          w_state_next           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = r_mem_we ? S_IDLE : S_RDWAIT;
      end
      S_RDWAIT: begin
        w_rdata_next          = bus.mem_rdata;
        w_rvalid_next[r_last] = 1'b1;
        w_state_next          = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= IW'(NCORE - 1);
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_last      <= w_last_next;
      r_gnt       <= w_gnt_next;
      r_rvalid    <= w_rvalid_next;
      r_rdata     <= w_rdata_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_busy      <= w_busy_next;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rvalid    = r_rvalid;
  assign bus.rdata     = r_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;

endmodule
